// File: rtl/sched_pkg.sv
// Shared types and image geometry for the block scheduler.
package sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEADIN,
    S_RUN,
    S_LEADOUT,
    S_DONE
  } sched_state_e;

  localparam int unsigned Y_COLS       = 40;
  localparam int unsigned UV_COLS      = 20;
  localparam int unsigned ROWS         = 30;
  localparam int unsigned Y_BLOCKS     = Y_COLS * ROWS;
  localparam int unsigned UV_BLOCKS    = UV_COLS * ROWS;
  localparam int unsigned TOTAL_BLOCKS = Y_BLOCKS + 2 * UV_BLOCKS;

  localparam int unsigned CNT_W  = 12;
  localparam int unsigned PERF_W = 24;

  typedef struct packed {
    logic [1:0] plane;
    logic [4:0] row;
    logic [5:0] col;
  } blk_coord_t;

  // Step to the next block: col first, then row, then plane (Y, U, V).
  function automatic blk_coord_t next_coord(input blk_coord_t c);
    blk_coord_t n;
    logic [5:0] last_col;
    n        = c;
    last_col = (c.plane == 2'd0) ? 6'(Y_COLS - 1) : 6'(UV_COLS - 1);
    if (c.col != last_col) begin
      n.col = c.col + 6'd1;
    end else begin
      n.col = '0;
      if (c.row != 5'(ROWS - 1)) begin
        n.row = c.row + 5'd1;
      end else begin
        n.row   = '0;
        n.plane = c.plane + 2'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter (LD/DQ and IDCT): sticky grant, alternating
// priority on ties, registered grants, combinational data-path mux.
module sram_arbiter
  import sched_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ld_req_i,
  input  logic [17:0] ld_addr_i,
  input  logic        ld_we_n_i,
  input  logic [15:0] ld_wdata_i,
  input  logic        idct_req_i,
  input  logic [17:0] idct_addr_i,
  input  logic        idct_we_n_i,
  input  logic [15:0] idct_wdata_i,
  output logic        ld_grant_o,
  output logic        idct_grant_o,
  output logic [17:0] sram_addr_o,
  output logic        sram_we_n_o,
  output logic [15:0] sram_wdata_o
);

  logic ld_grant_q, ld_grant_d;
  logic idct_grant_q, idct_grant_d;
  logic last_idct_q, last_idct_d;

  // Next grant: owner keeps it while requesting, otherwise pick a winner.
  always_comb begin
    ld_grant_d   = 1'b0;
    idct_grant_d = 1'b0;
    last_idct_d  = last_idct_q;
    if (ld_grant_q && ld_req_i) begin
      ld_grant_d = 1'b1;
    end else if (idct_grant_q && idct_req_i) begin
      idct_grant_d = 1'b1;
    end else if (ld_req_i && idct_req_i) begin
      if (last_idct_q) ld_grant_d = 1'b1;
      else             idct_grant_d = 1'b1;
    end else if (ld_req_i) begin
      ld_grant_d = 1'b1;
    end else if (idct_req_i) begin
      idct_grant_d = 1'b1;
    end
    if (ld_grant_d)        last_idct_d = 1'b0;
    else if (idct_grant_d) last_idct_d = 1'b1;
  end

  // Grant and tie-break history registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ld_grant_q   <= 1'b0;
      idct_grant_q <= 1'b0;
      last_idct_q  <= 1'b0;
    end else begin
      ld_grant_q   <= ld_grant_d;
      idct_grant_q <= idct_grant_d;
      last_idct_q  <= last_idct_d;
    end
  end

  // Route the granted requester to the SRAM; idle bus is write-disabled.
  always_comb begin
    sram_addr_o  = '0;
    sram_we_n_o  = 1'b1;
    sram_wdata_o = '0;
    if (ld_grant_q) begin
      sram_addr_o  = ld_addr_i;
      sram_we_n_o  = ld_we_n_i;
      sram_wdata_o = ld_wdata_i;
    end else if (idct_grant_q) begin
      sram_addr_o  = idct_addr_i;
      sram_we_n_o  = idct_we_n_i;
      sram_wdata_o = idct_wdata_i;
    end
  end

  assign ld_grant_o   = ld_grant_q;
  assign idct_grant_o = idct_grant_q;

endmodule

// File: rtl/block_scheduler.sv
// Image block scheduler: pipelines LD/DQ and IDCT over 2400 blocks with a
// ping-pong buffer, tracks IDCT block coordinates and arbitrates the SRAM.
// Optional: define SCHED_PERF_COUNT_EN to add the stall counters
// perf_ld_wait / perf_idct_wait.
module block_scheduler
  import sched_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        start,
  output logic        done,
  output logic        ld_new_block,
  input  logic        ld_block_done,
  output logic        idct_start,
  input  logic        idct_done,
  output logic        buf_sel,
  output logic [1:0]  idct_plane,
  output logic [4:0]  idct_block_row,
  output logic [5:0]  idct_block_col,
  input  logic        ld_sram_req,
  input  logic [17:0] ld_sram_address,
  input  logic        ld_sram_we_n,
  input  logic [15:0] ld_sram_write_data,
  output logic        ld_sram_grant,
  input  logic        idct_sram_req,
  input  logic [17:0] idct_sram_address,
  input  logic        idct_sram_we_n,
  input  logic [15:0] idct_sram_write_data,
  output logic        idct_sram_grant,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic [15:0] SRAM_write_data
`ifdef SCHED_PERF_COUNT_EN
  ,
  output logic [23:0] perf_ld_wait,
  output logic [23:0] perf_idct_wait
`endif
);

  sched_state_e     state_q;
  logic [CNT_W-1:0] ld_cnt_q;
  logic             ld_flag_q;
  logic             idct_flag_q;
  logic             buf_sel_q;
  blk_coord_t       coord_q;
  logic             ld_new_q;
  logic             idct_start_q;
  logic             done_q;

  // A completion counts whether it was latched earlier or arrives this cycle.
  logic ld_arrive, idct_arrive;
  assign ld_arrive   = ld_flag_q   | ld_block_done;
  assign idct_arrive = idct_flag_q | idct_done;

  // Scheduler FSM with registered pulses, buffer select and coordinates.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      ld_cnt_q     <= '0;
      ld_flag_q    <= 1'b0;
      idct_flag_q  <= 1'b0;
      buf_sel_q    <= 1'b0;
      coord_q      <= '0;
      ld_new_q     <= 1'b0;
      idct_start_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      ld_new_q     <= 1'b0;
      idct_start_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ld_new_q    <= 1'b1;
            ld_cnt_q    <= CNT_W'(1);
            ld_flag_q   <= 1'b0;
            idct_flag_q <= 1'b0;
            buf_sel_q   <= 1'b0;
            coord_q     <= '0;
            state_q     <= S_LEADIN;
          end
        end
        S_LEADIN: begin
          if (ld_block_done) begin
            buf_sel_q    <= ~buf_sel_q;
            ld_new_q     <= 1'b1;
            idct_start_q <= 1'b1;
            ld_cnt_q     <= ld_cnt_q + CNT_W'(1);
            coord_q      <= '0;
            state_q      <= S_RUN;
          end
        end
        S_RUN: begin
          if (ld_arrive && idct_arrive) begin
            ld_flag_q    <= 1'b0;
            idct_flag_q  <= 1'b0;
            buf_sel_q    <= ~buf_sel_q;
            idct_start_q <= 1'b1;
            coord_q      <= next_coord(coord_q);
            if (ld_cnt_q < CNT_W'(TOTAL_BLOCKS)) begin
              ld_new_q <= 1'b1;
              ld_cnt_q <= ld_cnt_q + CNT_W'(1);
            end else begin
              state_q <= S_LEADOUT;
            end
          end else begin
            ld_flag_q   <= ld_arrive;
            idct_flag_q <= idct_arrive;
          end
        end
        S_LEADOUT: begin
          if (idct_done) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign done           = done_q;
  assign ld_new_block   = ld_new_q;
  assign idct_start     = idct_start_q;
  assign buf_sel        = buf_sel_q;
  assign idct_plane     = coord_q.plane;
  assign idct_block_row = coord_q.row;
  assign idct_block_col = coord_q.col;

`ifdef SCHED_PERF_COUNT_EN
  logic [PERF_W-1:0] perf_ld_wait_q;
  logic [PERF_W-1:0] perf_idct_wait_q;

  // Stall counters: cycles in S_RUN where exactly one side has finished.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      perf_ld_wait_q   <= '0;
      perf_idct_wait_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      perf_ld_wait_q   <= '0;
      perf_idct_wait_q <= '0;
    end else if (state_q == S_RUN) begin
      if (idct_flag_q && !ld_flag_q) perf_ld_wait_q   <= perf_ld_wait_q + PERF_W'(1);
      if (ld_flag_q && !idct_flag_q) perf_idct_wait_q <= perf_idct_wait_q + PERF_W'(1);
    end
  end

  assign perf_ld_wait   = perf_ld_wait_q;
  assign perf_idct_wait = perf_idct_wait_q;
`endif

  sram_arbiter u_arb (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .ld_req_i     (ld_sram_req),
    .ld_addr_i    (ld_sram_address),
    .ld_we_n_i    (ld_sram_we_n),
    .ld_wdata_i   (ld_sram_write_data),
    .idct_req_i   (idct_sram_req),
    .idct_addr_i  (idct_sram_address),
    .idct_we_n_i  (idct_sram_we_n),
    .idct_wdata_i (idct_sram_write_data),
    .ld_grant_o   (ld_sram_grant),
    .idct_grant_o (idct_sram_grant),
    .sram_addr_o  (SRAM_address),
    .sram_we_n_o  (SRAM_we_n),
    .sram_wdata_o (SRAM_write_data)
  );

endmodule

// File: tb/tb_block_scheduler.sv
// Scoreboard bench for block_scheduler: scripted LD/IDCT stubs with random
// latencies, expected pulses queued from a timing/geometry model.
module tb_block_scheduler;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic        ld_new_block;
  logic        ld_block_done = 1'b0;
  logic        idct_start;
  logic        idct_done = 1'b0;
  logic        buf_sel;
  logic [1:0]  idct_plane;
  logic [4:0]  idct_block_row;
  logic [5:0]  idct_block_col;
  logic        ld_sram_req = 1'b0;
  logic [17:0] ld_sram_address = '0;
  logic        ld_sram_we_n = 1'b1;
  logic [15:0] ld_sram_write_data = '0;
  logic        ld_sram_grant;
  logic        idct_sram_req = 1'b0;
  logic [17:0] idct_sram_address = '0;
  logic        idct_sram_we_n = 1'b1;
  logic [15:0] idct_sram_write_data = '0;
  logic        idct_sram_grant;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_write_data;
`ifdef SCHED_PERF_COUNT_EN
  logic [23:0] perf_ld_wait;
  logic [23:0] perf_idct_wait;
`endif

  block_scheduler dut (
    .Clock                (Clock),
    .Reset                (Reset),
    .start                (start),
    .done                 (done),
    .ld_new_block         (ld_new_block),
    .ld_block_done        (ld_block_done),
    .idct_start           (idct_start),
    .idct_done            (idct_done),
    .buf_sel              (buf_sel),
    .idct_plane           (idct_plane),
    .idct_block_row       (idct_block_row),
    .idct_block_col       (idct_block_col),
    .ld_sram_req          (ld_sram_req),
    .ld_sram_address      (ld_sram_address),
    .ld_sram_we_n         (ld_sram_we_n),
    .ld_sram_write_data   (ld_sram_write_data),
    .ld_sram_grant        (ld_sram_grant),
    .idct_sram_req        (idct_sram_req),
    .idct_sram_address    (idct_sram_address),
    .idct_sram_we_n       (idct_sram_we_n),
    .idct_sram_write_data (idct_sram_write_data),
    .idct_sram_grant      (idct_sram_grant),
    .SRAM_address         (SRAM_address),
    .SRAM_we_n            (SRAM_we_n),
    .SRAM_write_data      (SRAM_write_data)
`ifdef SCHED_PERF_COUNT_EN
    ,
    .perf_ld_wait         (perf_ld_wait),
    .perf_idct_wait       (perf_idct_wait)
`endif
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit ld;
    bit idct;
    bit dn;
    int plane;
    int row;
    int col;
    bit bsel;
  } exp_t;

  exp_t expq[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_ld = 0;
  int n_idct = 0;
  int n_done = 0;
  int perf_ld_exp = 0;
  int perf_idct_exp = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected pulse record; idct coordinates follow the Y/U/V raster order.
  function automatic exp_t mk(input int c, input bit ld, input bit id, input bit dn,
                              input int idx);
    exp_t e;
    int   j;
    e.cyc = c; e.ld = ld; e.idct = id; e.dn = dn;
    e.bsel = bit'((idx + 1) % 2);
    if (idx < 1200) begin
      e.plane = 0; e.row = idx / 40; e.col = idx % 40;
    end else if (idx < 1800) begin
      j = idx - 1200; e.plane = 1; e.row = j / 20; e.col = j % 20;
    end else begin
      j = idx - 1800; e.plane = 2; e.row = j / 20; e.col = j % 20;
    end
    return e;
  endfunction

  // Monitor: every output pulse must match the head of the expected queue.
  always @(negedge Clock) begin
    exp_t e;
    if (ld_new_block || idct_start || done) begin
      n_ld   += int'(ld_new_block);
      n_idct += int'(idct_start);
      n_done += int'(done);
      if (expq.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("ld_new_block", int'(ld_new_block), int'(e.ld));
        chk("idct_start", int'(idct_start), int'(e.idct));
        chk("done", int'(done), int'(e.dn));
        if (e.idct) begin
          chk("idct_plane", int'(idct_plane), e.plane);
          chk("idct_row", int'(idct_block_row), e.row);
          chk("idct_col", int'(idct_block_col), e.col);
          chk("buf_sel", int'(buf_sel), int'(e.bsel));
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge Clock);
  endtask

  // Stubs: completions arrive lld / lid cycles after the pulse at cycle p.
  task automatic drive_dones(input int p, input int lld, input int lid,
                             input bit use_ld, input bit use_id);
    int m;
    m = 0;
    if (use_ld) m = lld;
    if (use_id && lid > m) m = lid;
    for (int d = 1; d <= m; d++) begin
      wait_cyc(p + d);
      ld_block_done = use_ld && (d == lld);
      idct_done     = use_id && (d == lid);
    end
    wait_cyc(p + m + 1);
    ld_block_done = 1'b0;
    idct_done     = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && expq.size() != 0; i++) @(negedge Clock);
    chk(name, expq.size(), 0);
  endtask

  // One image; stops after stop_at idct_starts when that is below 2400.
  task automatic run_image(input int stop_at, input int maxlat);
    int c0, p, lld, lid, m, ld_iss, n_id;
    bit newld;
    // Completions while idle must be ignored.
    wait_cyc(cyc + 1);
    ld_block_done = 1'b1; idct_done = 1'b1;
    wait_cyc(cyc + 1);
    ld_block_done = 1'b0; idct_done = 1'b0;
    wait_cyc(cyc + 2);
    n_ld = 0; n_idct = 0; n_done = 0;
    perf_ld_exp = 0; perf_idct_exp = 0;
    c0 = cyc;
    start = 1'b1;
    expq.push_back(mk(c0 + 1, 1'b1, 1'b0, 1'b0, 0));
    wait_cyc(c0 + 1);
    start = 1'b0;
    p = c0 + 1; ld_iss = 1;
    lld = $urandom_range(maxlat, 1);
    expq.push_back(mk(p + lld + 1, 1'b1, 1'b1, 1'b0, 0));
    drive_dones(p, lld, 0, 1'b1, 1'b0);
    p = p + lld + 1; ld_iss = 2; n_id = 1;
    while (n_id < 2400 && n_id < stop_at) begin
      lld = $urandom_range(maxlat, 1);
      lid = $urandom_range(maxlat, 1);
      m = (lld > lid) ? lld : lid;
      newld = (ld_iss < 2400);
      expq.push_back(mk(p + m + 1, newld, 1'b1, 1'b0, n_id));
      if (lld > lid) perf_ld_exp   += lld - lid;
      if (lid > lld) perf_idct_exp += lid - lld;
      drive_dones(p, lld, lid, 1'b1, 1'b1);
      if (newld) ld_iss++;
      n_id++;
      p = p + m + 1;
    end
    if (stop_at >= 2400) begin
      lid = $urandom_range(maxlat, 1);
      expq.push_back(mk(p + lid + 1, 1'b0, 1'b0, 1'b1, 0));
      drive_dones(p, 0, lid, 1'b0, 1'b1);
      // Stray completions during the done cycle must be ignored.
      ld_block_done = 1'b1; idct_done = 1'b1;
      wait_cyc(cyc + 1);
      ld_block_done = 1'b0; idct_done = 1'b0;
      drain("image_queue_drained");
      wait_cyc(cyc + 3);
      chk("ld_new_block_total", n_ld, 2400);
      chk("idct_start_total", n_idct, 2400);
      chk("done_total", n_done, 1);
`ifdef SCHED_PERF_COUNT_EN
      chk("perf_ld_wait", int'(perf_ld_wait), perf_ld_exp);
      chk("perf_idct_wait", int'(perf_idct_wait), perf_idct_exp);
`endif
    end else begin
      drain("abort_queue_drained");
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ld_new_block"}, int'(ld_new_block), 0);
    chk({tag, "_idct_start"}, int'(idct_start), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_buf_sel"}, int'(buf_sel), 0);
    chk({tag, "_plane"}, int'(idct_plane), 0);
    chk({tag, "_row"}, int'(idct_block_row), 0);
    chk({tag, "_col"}, int'(idct_block_col), 0);
    chk({tag, "_ld_grant"}, int'(ld_sram_grant), 0);
    chk({tag, "_idct_grant"}, int'(idct_sram_grant), 0);
    chk({tag, "_SRAM_we_n"}, int'(SRAM_we_n), 1);
    chk({tag, "_SRAM_address"}, int'(SRAM_address), 0);
    chk({tag, "_SRAM_write_data"}, int'(SRAM_write_data), 0);
  endtask

  // Arbiter: fixed opening sequence then random requests; model tracks owner.
  task automatic run_arbiter(input int ncyc);
    int own, last, nown;
    bit rl, ri;
    int ea, ew, ed;
    own = 0; last = 1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge Clock);
      if (i > 0) begin
        ea = 0; ew = 1; ed = 0;
        if (own == 1) begin
          ea = int'(ld_sram_address); ew = int'(ld_sram_we_n); ed = int'(ld_sram_write_data);
        end else if (own == 2) begin
          ea = int'(idct_sram_address); ew = int'(idct_sram_we_n); ed = int'(idct_sram_write_data);
        end
        chk("arb_ld_grant", int'(ld_sram_grant), int'(own == 1));
        chk("arb_idct_grant", int'(idct_sram_grant), int'(own == 2));
        chk("arb_SRAM_address", int'(SRAM_address), ea);
        chk("arb_SRAM_we_n", int'(SRAM_we_n), ew);
        chk("arb_SRAM_write_data", int'(SRAM_write_data), ed);
      end
      if (i == 0)       begin rl = 1'b1; ri = 1'b0; end
      else if (i == 1)  begin rl = 1'b0; ri = 1'b0; end
      else if (i <= 10) begin rl = 1'b1; ri = 1'b1; end
      else if (i <= 13) begin rl = 1'b1; ri = 1'b0; end
      else begin
        rl = bit'($urandom_range(1, 0));
        ri = bit'($urandom_range(1, 0));
      end
      ld_sram_req          = rl;
      idct_sram_req        = ri;
      ld_sram_address      = 18'($urandom);
      ld_sram_we_n         = 1'($urandom);
      ld_sram_write_data   = 16'($urandom);
      idct_sram_address    = 18'($urandom);
      idct_sram_we_n       = 1'($urandom);
      idct_sram_write_data = 16'($urandom);
      if (own == 1 && rl)      nown = 1;
      else if (own == 2 && ri) nown = 2;
      else if (rl && ri)       nown = (last == 1) ? 2 : 1;
      else if (rl)             nown = 1;
      else if (ri)             nown = 2;
      else                     nown = 0;
      if (nown != 0) last = nown;
      own = nown;
    end
    @(negedge Clock);
    ld_sram_req = 1'b0;
    idct_sram_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    chk_idle_outputs("reset");
`ifdef SCHED_PERF_COUNT_EN
    chk("reset_perf_ld_wait", int'(perf_ld_wait), 0);
    chk("reset_perf_idct_wait", int'(perf_idct_wait), 0);
`endif
    Reset = 1'b0;
    wait_cyc(cyc + 2);

    run_image(2400, 6);

    // Abort mid-image after an odd number of IDCT blocks, then restart.
    run_image(701, 8);
    chk("pre_abort_buf_sel", int'(buf_sel), 1);
    Reset = 1'b1;
    wait_cyc(cyc + 1);
    chk_idle_outputs("abort");
    wait_cyc(cyc + 1);
    Reset = 1'b0;
    wait_cyc(cyc + 2);
    run_image(2400, 8);

    run_arbiter(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/block_scheduler.md
BLOCK_SCHEDULER -- requirements
Module: block_scheduler

Interface
REQ-001 SHALL have: Clock  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have: Reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: start  in  1  one-cycle pulse, begins decode of one image (2400 blocks).
REQ-004 SHALL have: done  out  1  one-cycle pulse after the last IDCT block completes.
REQ-005 SHALL have: ld_new_block  out  1  one-cycle pulse, starts lossless-decode/dequant of the next block.
REQ-006 SHALL have: ld_block_done  in  1  one-cycle pulse, LD/DQ has written all 64 coefficients of its block.
REQ-007 SHALL have: idct_start  out  1  one-cycle pulse, starts IDCT on the previously decoded block.
REQ-008 SHALL have: idct_done  in  1  one-cycle pulse, IDCT has written its block back to SRAM.
REQ-009 SHALL have: buf_sel  out  1  ping-pong select; LD/DQ writes DP half buf_sel, IDCT reads half ~buf_sel.
REQ-010 SHALL have: idct_plane  out  2, idct_block_row  out  5, idct_block_col  out  6  (plane 0=Y, 1=U, 2=V); valid from the idct_start cycle until the next idct_start.
REQ-011 SHALL have per requester r in {ld, idct}: r_sram_req  in  1; r_sram_address  in  18; r_sram_we_n  in  1; r_sram_write_data  in  16; r_sram_grant  out  1.
REQ-012 SHALL have: SRAM_address  out  18; SRAM_we_n  out  1; SRAM_write_data  out  16  (muxed from the granted requester).

Function
REQ-013 States SHALL be S_IDLE, S_LEADIN, S_RUN, S_LEADOUT, S_DONE.
REQ-014 S_IDLE + start SHALL pulse ld_new_block on the next cycle and enter S_LEADIN; start outside S_IDLE SHALL be ignored.
REQ-015 S_LEADIN + ld_block_done SHALL toggle buf_sel and, on the next cycle, pulse ld_new_block and idct_start together, entering S_RUN.
REQ-016 In S_RUN, ld_done_flag and idct_done_flag SHALL latch their pulses; when both are set (including same-cycle arrival), buf_sel SHALL toggle, flags SHALL clear, and the next cycle SHALL pulse idct_start plus ld_new_block if LD blocks remain.
REQ-017 After the 2400th ld_new_block, the next pairing SHALL issue only idct_start and enter S_LEADOUT; idct_done there SHALL enter S_DONE.
REQ-018 S_DONE SHALL pulse done for one cycle, then return to S_IDLE.
REQ-019 IDCT coordinates SHALL advance column-major within a row: Y 40 cols x 30 rows (1200 blocks), then U 20x30 (600), then V 20x30 (600); col wraps 39->0 (Y) or 19->0 (U/V) with row+1; row 29 wrap SHALL advance plane and zero row/col.
REQ-020 Arbiter: grant SHALL be held while the owner keeps req high; on release or if idle, a single requester SHALL win; a tie SHALL go to the requester not granted last; grant SHALL take effect the cycle after req.
REQ-021 With no grant, SRAM_we_n SHALL be 1, SRAM_address and SRAM_write_data 0.
REQ-022 Spurious ld_block_done/idct_done in S_IDLE or S_DONE SHALL be ignored.

Reset
REQ-023 Reset SHALL force S_IDLE, all pulses/grants/coords/buf_sel/flags/counters 0, SRAM_we_n 1.
REQ-024 Reset mid-image SHALL abort; no pulse SHALL appear on the cycle after Reset deasserts.

Configuration
REQ-025 Macro SCHED_PERF_COUNT_EN defined: 24-bit outputs perf_ld_wait and perf_idct_wait SHALL count S_RUN cycles where only idct_done_flag (LD slow) resp. only ld_done_flag (IDCT slow) is set, cleared on start; undefined: ports and counters SHALL be absent, behaviour otherwise identical.

Structure
REQ-026 Package sched_pkg SHALL hold the state enum, Y_BLOCKS=1200, UV_BLOCKS=600, TOTAL_BLOCKS=2400, Y_COLS=40, UV_COLS=20, ROWS=30.
REQ-027 Arbitration SHALL be a sub-module sram_arbiter instantiated once.

Verification
REQ-028 Reset, start at cycle 5 -> ld_new_block at 6; ld_block_done at 40 -> ld_new_block, idct_start both at 41, buf_sel=1, coords (0,0,0).
REQ-029 S_RUN: idct_done at 100, ld_block_done at 130 -> next pulses at 131 only; same-cycle dones at 200 -> pulses at 201.
REQ-030 Full image with 20-cycle stubs -> exactly 2400 ld_new_block, 2400 idct_start, one done; coords (0,29,39)->(1,0,0) at block 1200, (1,29,19)->(2,0,0) at block 1800.
REQ-031 Both sram reqs high from idle, last grant ld -> idct granted; idct holds 8 cycles -> ld waits; idct drops -> ld granted next cycle.
REQ-032 Reset asserted at block 700 -> outputs zero next cycle; new start -> coords restart (0,0,0).
REQ-033 With SCHED_PERF_COUNT_EN, LD stub 30 cycles vs IDCT 20 -> perf_ld_wait = 10 x 2399 at done.
